// File: rtl/controllo_quadrato_if.sv
// controllo_quadrato_if: frame tick, mode/button inputs and position outputs of the square controller
interface controllo_quadrato_if;
    logic        frame_end;
    logic        auto;
    logic        btn_sx;
    logic        btn_dx;
    logic        btn_su;
    logic        btn_giu;
    logic [10:0] x_pos;
    logic [10:0] y_pos;
    logic        dir_x;
    logic        dir_y;
    logic        aggiornato;
    modport master (
        output frame_end, auto, btn_sx, btn_dx, btn_su, btn_giu,
        input  x_pos, y_pos, dir_x, dir_y, aggiornato
    );
    modport slave (
        input  frame_end, auto, btn_sx, btn_dx, btn_su, btn_giu,
        output x_pos, y_pos, dir_x, dir_y, aggiornato
    );
endinterface

// File: rtl/controllo_quadrato.sv
// controllo_quadrato: per-frame square position update, manual (clamped Y) or auto bounce, X wraps modulo H
module controllo_quadrato #(
    parameter int H       = 1280,
    parameter int V       = 1024,
    parameter int ALTEZZA = 100,
    parameter int X_INIT  = 640,
    parameter int Y_INIT  = 512,
    parameter int PASSO   = 4,
    parameter int DIV     = 2
) (
    input logic                 clk,
    input logic                 rst,
    controllo_quadrato_if.slave bus
);
    localparam logic [1:0] ATTESA  = 2'd0;
    localparam logic [1:0] CALCOLO = 2'd1;
    localparam logic [1:0] SCRIVI  = 2'd2;
    localparam logic [11:0] Y_MIN = 12'(ALTEZZA / 2);
    localparam logic [11:0] Y_MAX = 12'(V - ALTEZZA / 2);
    localparam logic [11:0] P     = 12'(PASSO);
    localparam logic [11:0] HH    = 12'(H);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;

    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic [10:0]   x_q, y_q, x_n, y_n;
    logic          dx_q, dy_q, dx_n, dy_n;
    logic [11:0]   x12, y12, xr, xl, yd, yu, x_c, y_c;
    logic          mv_r, mv_l, mv_d, mv_u, hit_hi, hit_lo, dy_c;

    assign x12    = {1'b0, x_q};
    assign y12    = {1'b0, y_q};
    assign xr     = x12 + P >= HH ? x12 + P - HH : x12 + P;
    assign xl     = x12 < P ? x12 + HH - P : x12 - P;
    assign yd     = y12 + P;
    assign yu     = y12 - P;
    // hit_lo is tested before subtracting so an underflowing step still lands on Y_MIN
    assign hit_hi = yd >= Y_MAX;
    assign hit_lo = y12 <= Y_MIN + P;
    assign mv_r   = bus.auto ? dx_q  : bus.btn_dx & ~bus.btn_sx;
    assign mv_l   = bus.auto ? ~dx_q : bus.btn_sx & ~bus.btn_dx;
    assign mv_d   = bus.auto ? dy_q  : bus.btn_giu & ~bus.btn_su;
    assign mv_u   = bus.auto ? ~dy_q : bus.btn_su & ~bus.btn_giu;
    assign x_c    = mv_r ? xr : mv_l ? xl : x12;
    assign y_c    = mv_d ? (hit_hi ? Y_MAX : yd) : mv_u ? (hit_lo ? Y_MIN : yu) : y12;
    assign dy_c   = bus.auto ? (dy_q ? ~hit_hi : hit_lo) : dy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= ATTESA;
            cnt  <= '0;
            x_q  <= 11'(X_INIT);
            y_q  <= 11'(Y_INIT);
            dx_q <= 1'b1;
            dy_q <= 1'b1;
            x_n  <= 11'(X_INIT);
            y_n  <= 11'(Y_INIT);
            dx_n <= 1'b1;
            dy_n <= 1'b1;
        end else if (st == ATTESA) begin
            if (bus.frame_end) begin
                cnt <= cnt == CW'(DIV - 1) ? '0 : cnt + 1'b1;
                st  <= cnt == CW'(DIV - 1) ? CALCOLO : ATTESA;
            end
        end else if (st == CALCOLO) begin
            x_n  <= 11'(x_c);
            y_n  <= 11'(y_c);
            dx_n <= dx_q;
            dy_n <= dy_c;
            st   <= SCRIVI;
        end else begin
            x_q  <= x_n;
            y_q  <= y_n;
            dx_q <= dx_n;
            dy_q <= dy_n;
            st   <= ATTESA;
        end
    end

    // the computed values are already visible during SCRIVI, the cycle flagged by aggiornato
    assign bus.aggiornato = st == SCRIVI;
    assign bus.x_pos      = bus.aggiornato ? x_n : x_q;
    assign bus.y_pos      = bus.aggiornato ? y_n : y_q;
    assign bus.dir_x      = bus.aggiornato ? dx_n : dx_q;
    assign bus.dir_y      = bus.aggiornato ? dy_n : dy_q;
endmodule

// File: doc/controllo_quadrato.md
Name: controllo_quadrato

Overview:
Sequential position controller for the square/frame hit-test blocks. It owns the X_POS/Y_POS centre coordinates that feed the rectangle and frame comparators, and updates them once per video frame. Updates follow either manual button commands or an autonomous bounce mode. Horizontal motion wraps around the H-pixel line, matching the comparators' wrap handling. Vertical motion is clamped in manual mode and bounces in auto mode.

Parameters:
H, 1280, active pixels per line; X wraps modulo H
V, 1024, active lines per frame
ALTEZZA, 100, square height; Y_MIN = ALTEZZA/2, Y_MAX = V - ALTEZZA/2
X_INIT, 640, X_POS reset value (must be < H)
Y_INIT, 512, Y_POS reset value (must be in [Y_MIN, Y_MAX])
PASSO, 4, pixels moved per update (1..ALTEZZA/2, < H)
DIV, 2, accepted frame ticks per position update (>= 1)

Ports:
CLK  in  1  pixel clock
RESET  in  1  asynchronous, active-high reset
FRAME_END  in  1  single-cycle pulse at end of active video
AUTO  in  1  1 = autonomous bounce mode, 0 = manual
BTN_SX  in  1  manual: move left (level)
BTN_DX  in  1  manual: move right (level)
BTN_SU  in  1  manual: move up (decreasing Y)
BTN_GIU  in  1  manual: move down (increasing Y)
X_POS  out  11  square centre X, always in [0, H-1]
Y_POS  out  11  square centre Y, always in [Y_MIN, Y_MAX]
DIR_X  out  1  auto direction, 1 = right
DIR_Y  out  1  auto direction, 1 = down
AGGIORNATO  out  1  one-cycle pulse when X_POS/Y_POS are written

Behaviour:
- Clocking and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: X_POS=X_INIT, Y_POS=Y_INIT, DIR_X=1, DIR_Y=1, AGGIORNATO=0, frame counter=0, state=ATTESA.
- Reset asserted mid-update aborts the update immediately; no partial write.
- FSM states: ATTESA, CALCOLO, SCRIVI.
- ATTESA:
  - On FRAME_END, if counter==DIV-1: clear counter and go to CALCOLO.
  - Otherwise on FRAME_END: counter+1, stay in ATTESA.
- CALCOLO (1 cycle):
  - Sample AUTO and all buttons.
  - Compute next X/Y/DIR into internal registers, using 12-bit arithmetic (no overflow).
  - Go to SCRIVI.
- SCRIVI (1 cycle):
  - Load X_POS/Y_POS/DIR_X/DIR_Y from the computed values.
  - AGGIORNATO=1 for this cycle only.
  - Return to ATTESA.
- Latency: outputs change exactly 2 cycles after the accepted FRAME_END edge. They are stable at all other times.
- FRAME_END arriving while in CALCOLO or SCRIVI is ignored: not counted, not queued.
- X wrap, applied in both modes:
  - Right: X+PASSO >= H gives X+PASSO-H, else X+PASSO.
  - Left: X < PASSO gives X+H-PASSO, else X-PASSO.
- Manual mode (AUTO=0):
  - BTN_SX and BTN_DX both high, or both low: X unchanged.
  - BTN_SU and BTN_GIU both high, or both low: Y unchanged.
  - Up: Y-PASSO, clamped to Y_MIN.
  - Down: Y+PASSO, clamped to Y_MAX.
  - DIR_X/DIR_Y hold their values.
- Auto mode (AUTO=1):
  - Buttons are ignored.
  - X steps one PASSO in DIR_X, with wrap.
  - Y steps one PASSO in DIR_Y.
  - If the down result is >= Y_MAX: Y=Y_MAX and DIR_Y<=0 in the same write.
  - If the up result is <= Y_MIN (underflow included): Y=Y_MIN and DIR_Y<=1.
  - DIR_X never changes.
- AUTO toggling takes effect only at the next CALCOLO. The mode switch itself never moves the square.
- DIV=1: every FRAME_END seen in ATTESA triggers an update.

Test Plan:
- Reset check: RESET pulse asserted asynchronously (no clock edge) -> X_POS=640, Y_POS=512, DIR_X=1, DIR_Y=1, AGGIORNATO=0.
- Divider and latency: DIV=2, AUTO=0, BTN_DX=1, FRAME_END pulses at cycles 10 and 20 -> no change after cycle 10; X_POS=644 at cycle 22; AGGIORNATO high only in cycle 22.
- Right wrap: DIV=1, X_POS driven to 1278, BTN_DX=1, one FRAME_END -> X_POS=2. Left wrap from X_POS=1, BTN_SX=1 -> X_POS=1277.
- Manual clamp and conflicts: Y_POS=52, BTN_SU=1, one tick -> Y_POS=50. Second tick -> still 50. BTN_SX=BTN_DX=1 -> X unchanged.
- Auto bounce: AUTO=1, Y_POS=972, DIR_Y=1, one tick -> Y_POS=974, DIR_Y=0, X_POS advanced by 4. Next tick -> Y_POS=970.
- Ignored tick and abort: second FRAME_END in the CALCOLO cycle -> exactly one update. RESET asserted during CALCOLO -> outputs return to reset values and there is no AGGIORNATO pulse.
